// File: rtl/pipe_pkg.sv
// pipe_pkg: per-stage control bundle types, their widths and bubble constants
package pipe_pkg;
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       pc_src;
    logic       imm_sel;
  } ex_ctrl_t;
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } mem_ctrl_t;
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic link;
    logic csr_we;
  } wb_ctrl_t;
  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } id_ex_ctrl_t;
  typedef struct packed {
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ex_mem_ctrl_t;
  localparam int EX_CTRL_W     = $bits(ex_ctrl_t);
  localparam int MEM_CTRL_W    = $bits(mem_ctrl_t);
  localparam int WB_CTRL_W     = $bits(wb_ctrl_t);
  localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
  localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
  localparam id_ex_ctrl_t  ID_EX_BUBBLE  = '0;
  localparam ex_mem_ctrl_t EX_MEM_BUBBLE = '0;
  localparam wb_ctrl_t     MEM_WB_BUBBLE = '0;
endpackage

// File: rtl/register_param.sv
// register_param: enable-gated register with synchronous reset to RESET_VAL
// ports: clk, reset (sync, active-high), en_i load enable, d_i next value, q_o held value
module register_param #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  always_ff @(posedge clk)
    if (reset) q_o <= RESET_VAL;
    else if (en_i) q_o <= d_i;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with optional skid entry, flush and stall counter
// ports: clk, reset (sync, active-high); in_valid/in_ready/in_data/in_ctrl upstream side;
//        flush squashes held and offered entries; out_valid/out_ready/out_data/out_ctrl downstream side;
//        stall_count saturating count of cycles with out_valid && !out_ready
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int                DATA_W      = 64,
  parameter int                CTRL_W      = ID_EX_CTRL_W,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = ID_EX_BUBBLE,
  parameter int                SKID        = 1,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_count
);
  localparam int EW = DATA_W + CTRL_W;
  logic          main_v_q, skid_v_q, main_v_d, skid_v_d;
  logic [1:0]    v_q;
  logic [EW-1:0] main_q, skid_q, main_d, in_ent;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic          in_acc, out_xfer, main_load_in, main_load_skid, skid_load;
  always_comb begin
    in_ent         = {in_data, in_ctrl};
    // with a skid entry in_ready comes straight from the skid valid flop, so out_ready never reaches it
    in_ready       = flush || ((SKID != 0) ? !skid_v_q : (!main_v_q || out_ready));
    out_xfer       = main_v_q && out_ready;
    in_acc         = in_valid && in_ready && !flush;
    main_load_skid = (SKID != 0) && skid_v_q && out_xfer && !flush;
    main_load_in   = in_acc && (!main_v_q || out_xfer);
    skid_load      = (SKID != 0) && in_acc && main_v_q && !out_xfer;
    main_d         = main_load_skid ? skid_q : in_ent;
    main_v_d       = !flush && (main_load_in || main_load_skid || (main_v_q && !out_xfer));
    skid_v_d       = !flush && (skid_load || (skid_v_q && !main_load_skid));
    cnt_d          = (main_v_q && !out_ready && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  register_param #(.WIDTH(EW)) u_main (
    .clk(clk), .reset(reset), .en_i(main_load_in || main_load_skid), .d_i(main_d), .q_o(main_q)
  );
  register_param #(.WIDTH(EW)) u_skid (
    .clk(clk), .reset(reset), .en_i(skid_load), .d_i(in_ent), .q_o(skid_q)
  );
  register_param #(.WIDTH(2)) u_valid (
    .clk(clk), .reset(reset), .en_i(1'b1), .d_i({main_v_d, skid_v_d}), .q_o(v_q)
  );
  assign {main_v_q, skid_v_q} = v_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign out_valid   = main_v_q;
  assign out_data    = main_q[EW-1:CTRL_W];
  assign out_ctrl    = main_v_q ? main_q[CTRL_W-1:0] : BUBBLE_CTRL;
  assign stall_count = cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized checks of both skid variants against a FIFO model
module tb_pipe_stage_reg;
  localparam logic [15:0] BUB = 16'h00A5;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] in_valid, in_ready, flush, out_valid, out_ready;
  logic [1:0][15:0] in_data, in_ctrl, out_data, out_ctrl;
  logic [3:0]  sc0;
  logic [15:0] sc1;
  int checks = 0;
  int errors = 0;
  int n [2];
  logic [31:0] e [2][2];
  int cnt [2];
  logic [15:0] ld [2];
  logic acc [2];
  int cmax [2] = '{15, 65535};
  always #5 clk = ~clk;
  pipe_stage_reg #(.DATA_W(16), .CTRL_W(16), .BUBBLE_CTRL(BUB), .SKID(0), .CNT_W(4)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_ctrl(in_ctrl[0]), .flush(flush[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .out_ctrl(out_ctrl[0]), .stall_count(sc0)
  );
  pipe_stage_reg #(.DATA_W(16), .CTRL_W(16), .BUBBLE_CTRL(BUB), .SKID(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_ctrl(in_ctrl[1]), .flush(flush[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .out_ctrl(out_ctrl[1]), .stall_count(sc1)
  );
  function automatic logic m_ready(int k);
    return flush[k] || (k == 1 ? (n[k] < 2) : (n[k] == 0 || out_ready[k]));
  endfunction
  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed %h expected %h", tag, k, obs, exp);
    end
  endtask
  task automatic tick();
    #1;
    if (!reset) for (int k = 0; k < 2; k++) chk("in_ready", k, 32'(in_ready[k]), 32'(m_ready(k)));
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        n[k] = 0; cnt[k] = 0; ld[k] = '0; acc[k] = 1'b0;
      end else begin
        logic ir, ox, ix;
        ir = m_ready(k);
        ox = n[k] > 0 && out_ready[k];
        ix = in_valid[k] && ir && !flush[k];
        acc[k] = in_valid[k] && ir;
        if (n[k] > 0 && !out_ready[k] && cnt[k] < cmax[k]) cnt[k]++;
        if (flush[k]) n[k] = 0;
        else begin
          if (ox) begin e[k][0] = e[k][1]; n[k]--; end
          if (ix) begin e[k][n[k]] = {in_data[k], in_ctrl[k]}; n[k]++; end
        end
        if (n[k] > 0) ld[k] = e[k][0][31:16];
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("out_valid", k, 32'(out_valid[k]), 32'(n[k] > 0));
      chk("out_ctrl", k, 32'(out_ctrl[k]), n[k] > 0 ? 32'(e[k][0][15:0]) : 32'(BUB));
      chk("out_data", k, 32'(out_data[k]), 32'(ld[k]));
      chk("stall_count", k, k == 1 ? 32'(sc1) : 32'(sc0), 32'(cnt[k]));
    end
  endtask
  initial begin
    in_valid = '0; flush = '0; out_ready = '1; in_data = '0; in_ctrl = '0; reset = 1'b1;
    tick();
    tick();
    chk("rst_valid", 1, 32'(out_valid[1]), 32'd0);
    chk("rst_ctrl", 1, 32'(out_ctrl[1]), 32'h00A5);
    chk("rst_data", 1, 32'(out_data[1]), 32'd0);
    chk("rst_stall", 1, 32'(sc1), 32'd0);
    chk("rst_in_ready", 1, 32'(in_ready[1]), 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 2'b11;
      in_data = {2{16'h10 + 16'(i)}};
      in_ctrl = {2{16'(i + 1)}};
      tick();
      chk("stream_data", 1, 32'(out_data[1]), 32'h10 + 32'(i));
      chk("stream_data", 0, 32'(out_data[0]), 32'h10 + 32'(i));
    end
    in_valid = '0;
    tick();
    tick();
    chk("stream_stall", 1, 32'(sc1), 32'd0);
    out_ready = 2'b01;
    in_valid = 2'b10; in_data[1] = 16'h0A0A; in_ctrl[1] = 16'h000A;
    tick();
    in_data[1] = 16'h0B0B; in_ctrl[1] = 16'h000B;
    tick();
    chk("skid_full_ready", 1, 32'(in_ready[1]), 32'd0);
    in_data[1] = 16'h0C0C; in_ctrl[1] = 16'h000C;
    tick();
    chk("skid_hold_a", 1, 32'(out_data[1]), 32'h0A0A);
    out_ready = '1;
    tick();
    chk("drain_b", 1, 32'(out_data[1]), 32'h0B0B);
    tick();
    chk("drain_c", 1, 32'(out_data[1]), 32'h0C0C);
    in_valid = '0;
    tick();
    chk("drain_empty", 1, 32'(out_valid[1]), 32'd0);
    chk("skid_stall", 1, 32'(sc1), 32'd2);
    out_ready = 2'b01;
    in_valid = 2'b10; in_data[1] = 16'h0D0D; in_ctrl[1] = 16'h000D;
    tick();
    in_data[1] = 16'h0E0E; in_ctrl[1] = 16'h000E;
    tick();
    in_data[1] = 16'h0F0F; in_ctrl[1] = 16'h000F; flush = 2'b10;
    tick();
    chk("flush_valid", 1, 32'(out_valid[1]), 32'd0);
    chk("flush_ctrl", 1, 32'(out_ctrl[1]), 32'h00A5);
    flush = '0; in_valid = '0; out_ready = '1;
    #1;
    chk("flush_in_ready", 1, 32'(in_ready[1]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_c", 1, 32'(out_valid[1]), 32'd0);
    end
    out_ready = 2'b10;
    in_valid = 2'b01; in_data[0] = 16'h6006; in_ctrl[0] = 16'h0006;
    tick();
    in_valid = '0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", 0, 32'(sc0), 32'hF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_valid", 0, 32'(out_valid[0]), 32'd0);
    chk("midrst_stall", 0, 32'(sc0), 32'd0);
    in_valid = 2'b01; in_data[0] = 16'h7007; in_ctrl[0] = 16'h0007;
    tick();
    in_valid = '0;
    chk("midrst_new_valid", 0, 32'(out_valid[0]), 32'd1);
    chk("midrst_new_data", 0, 32'(out_data[0]), 32'h7007);
    out_ready = '1;
    tick();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 2'($urandom);
      out_ready = 2'($urandom);
      flush     = {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0};
      in_data   = 32'($urandom);
      in_ctrl   = 32'($urandom);
      reset     = $urandom_range(0, 99) == 0;
      tick();
    end
    reset = 1'b0; in_valid = '0; flush = '0; out_ready = '1;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
